// File: rtl/line_burst_adaptor_if.sv
// Bundle for the line adaptor: cache-arbiter line port plus the physical-memory beat port.
// Latency: none, wiring only.
// Backpressure: memory paces beats with resp_i; the arbiter waits for the resp_o pulse.
// Ports: arbiter side read_i/write_i/address_i/line_i -> line_o/resp_o;
//        memory side burst_i/resp_i -> burst_o/address_o/read_o/write_o.
// slave = the adaptor's view, master = the view of whatever drives it.
interface line_burst_adaptor_if #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,
  parameter int ADDR_W = 32
);
  // arbiter side
  logic              read_i;
  logic              write_i;
  logic [ADDR_W-1:0] address_i;
  logic [LINE_W-1:0] line_i;
  logic [LINE_W-1:0] line_o;
  logic              resp_o;
  // memory side
  logic [BEAT_W-1:0] burst_i;
  logic              resp_i;
  logic [BEAT_W-1:0] burst_o;
  logic [ADDR_W-1:0] address_o;
  logic              read_o;
  logic              write_o;

  modport slave (
    input  read_i, write_i, address_i, line_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output read_i, write_i, address_i, line_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/line_burst_adaptor.sv
// Converts one cacheline read/write into a BEATS-beat burst on memory and reassembles read data.
// Latency: request seen cycle 0, burst from cycle 1, resp_o one cycle after the last beat.
// Backpressure: one transaction in flight; resp_i gaps stall the beat counter, requests held.
// Ports: clk, rst (sync, active-high); bus (line_burst_adaptor_if.slave) carries the
//        arbiter line request/response and the memory beat request/handshake.
module line_burst_adaptor #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,   // LINE_W must be a whole multiple of BEAT_W
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  line_burst_adaptor_if.slave  bus
);
  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(LINE_W / 8);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [ADDR_W-1:0]             addr_q, addr_d;
  // Lines kept as beat arrays so beat k is simply element k (beat 0 = LSBs).
  logic [BEATS-1:0][BEAT_W-1:0]  wline_q, wline_d;
  logic [BEATS-1:0][BEAT_W-1:0]  rline_q, rline_d;
  logic                          last_beat;
  logic                          unused_addr_bits;

  // Offset bits within the line are dropped on purpose.
  assign unused_addr_bits = ^bus.address_i[OFF_W-1:0];

  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;
    case (state_q)
      IDLE: begin
        // resp_i is ignored here; only a request moves us on. Write wins a tie.
        if (bus.read_i || bus.write_i) begin
          addr_d  = {bus.address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          wline_d = bus.line_i;
          cnt_d   = '0;
          state_d = bus.write_i ? WR : RD;
        end
      end
      RD: begin
        if (bus.resp_i) begin
          rline_d[cnt_q] = bus.burst_i;
          // Wraps to 0 exactly on the final beat.
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat) state_d = DONE;
        end
      end
      WR: begin
        if (bus.resp_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;  // requests are deliberately not sampled here
      default: state_d = IDLE;
    endcase
  end

  // Request strobes come straight from state so they drop on the DONE entry edge.
  assign bus.read_o    = (state_q == RD);
  assign bus.write_o   = (state_q == WR);
  assign bus.resp_o    = (state_q == DONE);
  assign bus.address_o = addr_q;
  assign bus.burst_o   = wline_q[cnt_q];
  assign bus.line_o    = rline_q;
endmodule

// File: tb/tb_line_burst_adaptor.sv
module tb_line_burst_adaptor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  line_burst_adaptor_if ifc ();
  line_burst_adaptor dut (.clk(clk), .rst(rst), .bus(ifc));

  typedef struct {
    bit           is_wr;
    logic [31:0]  addr;
    logic [255:0] line;   // expected line_o at resp_o
    logic [255:0] wline;  // expected write data, beat 0 first
  } exp_t;

  exp_t        exp_q[$];
  bit          pat_q[$];     // memory resp_i pattern for the current burst
  bit          cur_pat[$];
  logic [63:0] rd_q[$];      // read beats the memory will return
  logic [63:0] cap_wr[$];    // write beats the memory accepted
  int          bcount = 0;   // beats handed over by the memory model
  bit          stray = 1'b0;
  logic [255:0] last_rd = '0;
  int          errors = 0;
  int          checks = 0;

  function automatic void chk(input string nm, input logic [255:0] act, input logic [255:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic void mk_pat(input int maxgap);
    cur_pat.delete();
    for (int i = 0; i < 4; i++) begin
      int g;
      g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      for (int j = 0; j < g; j++) cur_pat.push_back(1'b0);
      cur_pat.push_back(1'b1);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model: answers requests per the preloaded pattern, returns/captures beats.
  initial begin
    ifc.resp_i  = 1'b0;
    ifc.burst_i = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ifc.resp_i = 1'b0;
        bcount = 0;
        cap_wr.delete();
      end else if (ifc.read_o || ifc.write_o) begin
        bit b;
        b = 1'b1;
        if (pat_q.size() > 0) b = pat_q.pop_front();
        ifc.resp_i = b;
        if (b) begin
          bcount++;
          if (ifc.write_o) cap_wr.push_back(ifc.burst_o);
          else ifc.burst_i = (rd_q.size() > 0) ? rd_q.pop_front() : 64'h0;
        end else begin
          ifc.burst_i = {$urandom, $urandom};
        end
      end else begin
        ifc.resp_i  = stray;
        ifc.burst_i = {$urandom, $urandom};
      end
    end
  end

  // Monitor: observes bursts and checks each resp_o against the scoreboard.
  initial begin
    bit saw_rd, saw_wr, addr_bad, prev_resp;
    logic [31:0] addr_seen;
    int bstart;
    exp_t e;
    saw_rd = 0; saw_wr = 0; addr_bad = 0; prev_resp = 0; addr_seen = '0; bstart = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        saw_rd = 0; saw_wr = 0; addr_bad = 0; prev_resp = 0; bstart = 0;
      end else begin
        if (ifc.read_o || ifc.write_o) begin
          chk("rd_wr_exclusive", ifc.read_o & ifc.write_o, 0);
          if (!saw_rd && !saw_wr) addr_seen = ifc.address_o;
          else if (ifc.address_o !== addr_seen) addr_bad = 1;
          saw_rd |= ifc.read_o;
          saw_wr |= ifc.write_o;
        end
        if (ifc.resp_o) begin
          chk("resp_one_cycle", prev_resp, 0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got resp_o=1 expected no transaction");
          end else begin
            e = exp_q.pop_front();
            chk("burst_kind", {saw_wr, saw_rd}, {e.is_wr, !e.is_wr});
            chk("address_o", addr_seen, e.addr);
            chk("address_stable", addr_bad, 0);
            chk("line_o", ifc.line_o, e.line);
            chk("beat_count", bcount - bstart, 4);
            if (e.is_wr) begin
              chk("wr_beats", cap_wr.size(), 4);
              for (int i = 0; i < 4 && i < cap_wr.size(); i++)
                chk("burst_o", cap_wr[i], e.wline[i*64 +: 64]);
            end
          end
          cap_wr.delete();
          bstart = bcount;
          saw_rd = 0; saw_wr = 0; addr_bad = 0;
        end
        prev_resp = ifc.resp_o;
      end
    end
  end

  // Reference model: a read returns exactly the beats supplied; a write leaves line_o alone.
  task automatic arm(input bit wr, input logic [31:0] addr, input logic [255:0] wl,
                     input logic [255:0] rl, output int lat);
    exp_t e;
    e.is_wr = wr;
    e.addr  = {addr[31:5], 5'b0};
    e.wline = wl;
    if (!wr) begin
      for (int i = 0; i < 4; i++) rd_q.push_back(rl[i*64 +: 64]);
      last_rd = rl;
    end
    e.line = last_rd;
    pat_q  = cur_pat;
    lat    = cur_pat.size() + 1;
    exp_q.push_back(e);
  endtask

  task automatic wait_resp(input int lat, input int start);
    int cyc;
    cyc = start;
    while (!ifc.resp_o && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("latency", cyc, lat);
  endtask

  task automatic txn(input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [255:0] wl, input logic [255:0] rl);
    int lat;
    arm(wr, addr, wl, rl, lat);
    ifc.read_i = rd; ifc.write_i = wr; ifc.address_i = addr; ifc.line_i = wl;
    tick();
    // Requester inputs are don't-care once latched: scramble them.
    ifc.read_i = 1'b0; ifc.write_i = 1'b0;
    ifc.address_i = $urandom; ifc.line_i = rand256();
    wait_resp(lat, 1);
    tick();
  endtask

  initial begin
    logic [255:0] l;
    int lat, n, b0;
    rst = 1'b1;
    ifc.read_i = 0; ifc.write_i = 0; ifc.address_i = '0; ifc.line_i = '0;
    repeat (3) tick();
    chk("rst_read_o", ifc.read_o, 0);
    chk("rst_write_o", ifc.write_o, 0);
    chk("rst_resp_o", ifc.resp_o, 0);
    chk("rst_line_o", ifc.line_o, 0);
    chk("rst_address_o", ifc.address_o, 0);
    chk("rst_burst_o", ifc.burst_o, 0);
    rst = 1'b0;
    tick();

    // Zero-wait read.
    mk_pat(0);
    l = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
    txn(1, 0, 32'h0000_1234, rand256(), l);

    // Write, zero wait.
    mk_pat(0);
    l = {64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC, 64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA};
    txn(0, 1, 32'h8000_0040, l, '0);

    // Gapped read 1,0,0,1,1,0,1.
    cur_pat.delete();
    cur_pat.push_back(1); cur_pat.push_back(0); cur_pat.push_back(0); cur_pat.push_back(1);
    cur_pat.push_back(1); cur_pat.push_back(0); cur_pat.push_back(1);
    txn(1, 0, 32'h1234_5678, rand256(), rand256());

    // Simultaneous read and write: write wins.
    mk_pat(1);
    txn(1, 1, 32'hCAFE_F00D, rand256(), '0);

    // Reset after beat 2 of a read.
    cur_pat.delete();
    cur_pat.push_back(1); cur_pat.push_back(1);
    for (int i = 0; i < 8; i++) cur_pat.push_back(0);
    l = rand256();
    for (int i = 0; i < 4; i++) rd_q.push_back(l[i*64 +: 64]);
    pat_q = cur_pat;
    b0 = bcount;
    ifc.read_i = 1; ifc.address_i = 32'h0000_4000;
    tick();
    ifc.read_i = 0;
    n = 0;
    while (bcount - b0 < 2 && n < 50) begin
      tick();
      n++;
    end
    chk("abort_two_beats", bcount - b0, 2);
    rst = 1'b1;
    tick();
    chk("abort_read_o", ifc.read_o, 0);
    chk("abort_resp_o", ifc.resp_o, 0);
    chk("abort_line_o", ifc.line_o, 0);
    rst = 1'b0;
    rd_q.delete(); pat_q.delete();
    last_rd = '0;
    tick();
    mk_pat(0);
    txn(1, 0, 32'h0000_4000, rand256(), rand256());

    // Back-to-back: read_i held through resp_o.
    mk_pat(0);
    arm(0, 32'h0000_2000, '0, rand256(), lat);
    ifc.read_i = 1; ifc.address_i = 32'h0000_2000;
    tick();
    wait_resp(lat, 1);
    mk_pat(1);
    arm(0, 32'h0000_3020, '0, rand256(), lat);
    ifc.address_i = 32'h0000_3020;
    tick();
    chk("b2b_idle_read_o", ifc.read_o, 0);
    chk("b2b_idle_resp_o", ifc.resp_o, 0);
    tick();
    chk("b2b_restart_read_o", ifc.read_o, 1);
    ifc.read_i = 0;
    wait_resp(lat, 1);
    tick();

    // Stray resp_i while idle.
    stray = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stray_resp_o", ifc.resp_o, 0);
      chk("stray_read_o", ifc.read_o | ifc.write_o, 0);
      chk("stray_line_o", ifc.line_o, last_rd);
    end
    stray = 1'b0;
    tick();

    // Randomized mix.
    for (int t = 0; t < 20; t++) begin
      bit r, w;
      r = 1'($urandom);
      w = r ? 1'($urandom) : 1'b1;
      mk_pat(3);
      txn(r, w, $urandom, rand256(), rand256());
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
